// File: rtl/mux_2_bits_arbiter.sv
// mux_2_bits_arbiter
// Upstream stage for a 2-bit two-input selector. Two independent
// valid/ready sources (A and B) each fill a one-entry holding register.
// A round-robin FSM picks which held word the selector presents to the
// consumer, so neither source can starve the other.
//
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   a_valid/a_ready    source A handshake, a_data is the offered word
//   b_valid/b_ready    source B handshake, b_data is the offered word
//   in0, in1           holding register contents (A, B) to the selector
//   sel                selector control: 1 routes in0 (A), 0 routes in1 (B)
//   out_valid          selected word is valid at the selector output
//   out_ready          consumer accepts when out_valid && out_ready
module mux_2_bits_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             full_a_q, full_a_d;
  logic             full_b_q, full_b_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic             sel_q, sel_d;
  // Round-robin pointer: 1 means A has priority on the next tie.
  logic             ptr_q, ptr_d;
  logic             a_hs;
  logic             b_hs;

  // Ready is gated by rst_n so no word can be accepted during reset.
  // There is deliberately no bypass from out_ready: a register being
  // drained this cycle is only refillable in the following cycle.
  assign a_ready   = rst_n & ~full_a_q;
  assign b_ready   = rst_n & ~full_b_q;
  assign a_hs      = a_valid & a_ready;
  assign b_hs      = b_valid & b_ready;

  assign in0       = in0_q;
  assign in1       = in1_q;
  assign sel       = sel_q;
  assign out_valid = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    full_a_d = full_a_q;
    full_b_d = full_b_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;

    if (a_hs) begin
      in0_d    = a_data;
      full_a_d = 1'b1;
    end
    if (b_hs) begin
      in1_d    = b_data;
      full_b_d = 1'b1;
    end

    // Grant decisions look only at the registered full flags, which is
    // what gives the two-edge latency from handshake to presentation.
    // A granted register is full, so its handshake cannot coincide with
    // the drain below and the two updates never conflict.
    case (state_q)
      IDLE: begin
        if (full_a_q && full_b_q) begin
          state_d = ptr_q ? GRANT_A : GRANT_B;
        end else if (full_a_q) begin
          state_d = GRANT_A;
        end else if (full_b_q) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (out_ready) begin
          full_a_d = 1'b0;
          ptr_d    = 1'b0;
          state_d  = full_b_q ? GRANT_B : IDLE;
        end
      end
      GRANT_B: begin
        if (out_ready) begin
          full_b_d = 1'b0;
          ptr_d    = 1'b1;
          state_d  = full_a_q ? GRANT_A : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // sel follows the grant and keeps its last value while idle.
    if (state_d == GRANT_A) begin
      sel_d = 1'b1;
    end else if (state_d == GRANT_B) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
      sel_q    <= 1'b1;
      ptr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      full_a_q <= full_a_d;
      full_b_q <= full_b_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux_2_bits_arbiter.sv
// tb_mux_2_bits_arbiter
// Directed bench for mux_2_bits_arbiter. Accepted source words go into
// per-source expectation queues and are popped when the consumer side
// transfers; directed steps additionally pin down grant order, latency,
// backpressure stability and reset behaviour.
module tb_mux_2_bits_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid;
  logic       a_ready;
  logic [1:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_data;
  logic [1:0] in0;
  logic [1:0] in1;
  logic       sel;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];
  bit         src_log[$];
  int         pushed_a = 0;
  int         pushed_b = 0;
  int         popped_a = 0;
  int         popped_b = 0;
  int         xfer_total = 0;
  int         xsnap;
  bit         hs_a, hs_b;
  bit         alt_mode = 1'b0;
  bit         have_last = 1'b0;
  bit         last_sel = 1'b0;

  mux_2_bits_arbiter #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: at the negedge record handshakes into the queues and
  // score any consumer transfer, then advance past the next rising edge.
  task automatic tick();
    hs_a = 1'b0;
    hs_b = 1'b0;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (a_valid && a_ready) begin
        qa.push_back(a_data);
        pushed_a++;
        hs_a = 1'b1;
      end
      if (b_valid && b_ready) begin
        qb.push_back(b_data);
        pushed_b++;
        hs_b = 1'b1;
      end
      if (out_valid === 1'b1 && out_ready) begin
        xfer_total++;
        src_log.push_back(sel);
        if (alt_mode) begin
          if (have_last) chk("alternate", {7'd0, sel}, {7'd0, ~last_sel});
          have_last = 1'b1;
        end
        last_sel = sel;
        if (sel) begin
          chk("xfer_a_word_held", {7'd0, qa.size() != 0}, 8'd1);
          if (qa.size() != 0) begin
            chk("xfer_a_data", {6'd0, in0}, {6'd0, qa.pop_front()});
            popped_a++;
          end
        end else begin
          chk("xfer_b_word_held", {7'd0, qb.size() != 0}, 8'd1);
          if (qb.size() != 0) begin
            chk("xfer_b_data", {6'd0, in1}, {6'd0, qb.pop_front()});
            popped_b++;
          end
        end
      end
    end
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      qa.delete();
      qb.delete();
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 2'b11;
    b_data    = 2'b11;
    out_ready = 1'b0;

    // Reset with both sources requesting
    tick();
    tick();
    chk("rst_a_ready", {7'd0, a_ready}, 8'd0);
    chk("rst_b_ready", {7'd0, b_ready}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_sel", {7'd0, sel}, 8'd1);
    chk("rst_in0", {6'd0, in0}, 8'd0);
    chk("rst_in1", {6'd0, in1}, 8'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("rel_a_ready", {7'd0, a_ready}, 8'd1);
    chk("rel_b_ready", {7'd0, b_ready}, 8'd1);

    // Single A word
    out_ready = 1'b1;
    a_valid   = 1'b1;
    a_data    = 2'b10;
    tick();
    a_valid = 1'b0;
    chk("single_in0", {6'd0, in0}, 8'h02);
    chk("single_not_yet_valid", {7'd0, out_valid}, 8'd0);
    chk("single_a_full", {7'd0, a_ready}, 8'd0);
    tick();
    chk("single_valid", {7'd0, out_valid}, 8'd1);
    chk("single_sel", {7'd0, sel}, 8'd1);
    tick();
    chk("single_done_valid", {7'd0, out_valid}, 8'd0);
    chk("single_done_ready", {7'd0, a_ready}, 8'd1);
    chk("single_xfers", xfer_total[7:0], 8'd1);

    // Simultaneous A and B after reset: pointer at A
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    a_valid = 1'b1;
    a_data  = 2'b01;
    b_valid = 1'b1;
    b_data  = 2'b11;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("simA_sel_first", {7'd0, sel}, 8'd1);
    chk("simA_valid_first", {7'd0, out_valid}, 8'd1);
    chk("simA_in0", {6'd0, in0}, 8'h01);
    tick();
    chk("simA_sel_second", {7'd0, sel}, 8'd0);
    chk("simA_in1", {6'd0, in1}, 8'h03);
    tick();
    chk("simA_idle", {7'd0, out_valid}, 8'd0);
    chk("simA_order_1", {7'd0, src_log[src_log.size()-2]}, 8'd1);
    chk("simA_order_2", {7'd0, src_log[src_log.size()-1]}, 8'd0);

    // One A word moves the pointer to B, then simultaneous again
    a_valid = 1'b1;
    a_data  = 2'b10;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    a_valid = 1'b1;
    a_data  = 2'b00;
    b_valid = 1'b1;
    b_data  = 2'b01;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("simB_sel_first", {7'd0, sel}, 8'd0);
    chk("simB_in1", {6'd0, in1}, 8'h01);
    tick();
    chk("simB_sel_second", {7'd0, sel}, 8'd1);
    chk("simB_in0", {6'd0, in0}, 8'h00);
    tick();
    chk("simB_idle", {7'd0, out_valid}, 8'd0);

    // Backpressure on a B grant while A fills behind it
    out_ready = 1'b0;
    b_valid   = 1'b1;
    b_data    = 2'b10;
    tick();
    b_valid = 1'b0;
    tick();
    chk("bp_grant_b", {7'd0, sel}, 8'd0);
    a_valid = 1'b1;
    a_data  = 2'b01;
    xsnap   = xfer_total;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_valid = 1'b0;
      chk("bp_sel_stable", {7'd0, sel}, 8'd0);
      chk("bp_in1_stable", {6'd0, in1}, 8'h02);
      chk("bp_valid_stable", {7'd0, out_valid}, 8'd1);
    end
    chk("bp_a_ready_low", {7'd0, a_ready}, 8'd0);
    chk("bp_no_xfer", xfer_total[7:0], xsnap[7:0]);
    out_ready = 1'b1;
    tick();
    chk("bp_then_a_sel", {7'd0, sel}, 8'd1);
    chk("bp_then_a_valid", {7'd0, out_valid}, 8'd1);
    chk("bp_then_a_in0", {6'd0, in0}, 8'h01);
    tick();
    chk("bp_drained", {7'd0, out_valid}, 8'd0);

    // Saturation with incrementing data on both sources
    alt_mode  = 1'b1;
    have_last = 1'b0;
    xsnap     = xfer_total;
    a_valid   = 1'b1;
    b_valid   = 1'b1;
    a_data    = 2'b00;
    b_data    = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hs_a) a_data = a_data + 2'd1;
      if (hs_b) b_data = b_data + 2'd1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    alt_mode = 1'b0;
    chk("sat_qa_empty", qa.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    chk("sat_qb_empty", qb.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    chk("sat_a_count", popped_a[7:0], pushed_a[7:0]);
    chk("sat_b_count", popped_b[7:0], pushed_b[7:0]);
    chk("sat_progress", (xfer_total - xsnap) >= 10 ? 8'd1 : 8'd0, 8'd1);
    chk("sat_idle", {7'd0, out_valid}, 8'd0);

    // Reset during a stalled A grant
    out_ready = 1'b0;
    a_valid   = 1'b1;
    a_data    = 2'b11;
    tick();
    a_valid = 1'b0;
    tick();
    chk("mid_grant_a", {7'd0, sel}, 8'd1);
    chk("mid_valid", {7'd0, out_valid}, 8'd1);
    chk("mid_in0", {6'd0, in0}, 8'h03);
    xsnap     = xfer_total;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_sel", {7'd0, sel}, 8'd1);
    chk("mid_rst_in0", {6'd0, in0}, 8'd0);
    chk("mid_rst_no_xfer", xfer_total[7:0], xsnap[7:0]);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_a_ready", {7'd0, a_ready}, 8'd1);
    chk("mid_rel_b_ready", {7'd0, b_ready}, 8'd1);
    tick();
    tick();
    tick();
    chk("mid_word_dropped", {7'd0, out_valid}, 8'd0);
    chk("mid_never_xfer", xfer_total[7:0], xsnap[7:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
